demux4_scan_receiver: RTL and testbench
=======================================

# demux4_scan_receiver

Receiving end of the 4-to-1 scanned lane multiplexer. The transmitter sends one lane bit per beat over a single wire along with the 2-bit lane select. This block captures the beats in order 0,1,2,3 and rebuilds the 4-bit parallel lane word (key/note state for lanes 0–3). It publishes the word atomically once per complete frame, with per-lane rising-edge pulses. It also detects out-of-order beats and stalled frames.

## Interface
Parameters:
- TIMEOUT, default 16: maximum idle cycles allowed between beats inside a frame. Legal range is 2 to 65535.
- TW, default $clog2(TIMEOUT+1): width of the gap timer. Derived; not overridden.

Ports:
- clk, input, 1: single clock. Everything samples on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- y_in, input, 1: serial lane bit (transmitter's Y).
- s_in, input, 2: lane index of the current beat (transmitter's S).
- beat_valid, input, 1: y_in/s_in are meaningful this cycle.
- q, output, 4: last committed lane word. q[i] is lane i.
- frame_valid, output, 1: one-cycle pulse when q updates.
- rise, output, 4: one-cycle pulse per lane whose q bit changed 0→1 at this commit.
- sync_err, output, 1: one-cycle pulse on an out-of-order beat.
- timeout_err, output, 1: one-cycle pulse when a partial frame is abandoned.

## Operation
- Internal state:
  - shadow[3:0]: capture register.
  - exp[1:0]: expected next lane.
  - timer[TW-1:0]: gap counter.
  - in_frame: 1 after a lane-0 beat is accepted and until commit or abort.
- Accepted beat (beat_valid && s_in==exp):
  - shadow[exp] <= y_in.
  - exp <= exp+1 (wraps 3→0).
  - timer <= 0.
  - in_frame <= (exp!=3).
- Commit (accepted beat with s_in==3):
  - q <= {y_in, shadow[2:0]}.
  - frame_valid <= 1.
  - rise <= new_q & ~old_q.
- Out-of-order beat (beat_valid && s_in!=exp):
  - sync_err <= 1.
  - The partial frame is discarded; q is unchanged.
  - If s_in==0: treat the beat as a fresh lane-0 capture. shadow[0] <= y_in, exp <= 1, in_frame <= 1.
  - Otherwise: exp <= 0, in_frame <= 0.
- Timeout: when in_frame and no beat_valid, timer increments. When timer reaches TIMEOUT-1 in a cycle with no beat:
  - timeout_err <= 1.
  - exp <= 0, in_frame <= 0, timer <= 0.
  - q is unchanged.
- A beat arriving in the same cycle the timer would expire is processed normally. Beats take priority and no timeout fires.
- The timer holds at 0 while not in_frame.
- shadow bits of an aborted frame are never visible on q.
- rise is computed against q as it was before the commit. A commit with an identical word gives frame_valid=1 and rise=0.

## Timing
- Reset values (asynchronous, immediate on rst_n low): all of the following are 0.
  - Outputs: q, frame_valid, rise, sync_err, timeout_err.
  - Internal state: shadow, exp, timer, in_frame.
- Latency: q, frame_valid and rise change on the clock edge that samples the lane-3 beat. They are visible the cycle after that beat is presented.
- sync_err and timeout_err are registered. Each asserts one cycle after its cause and deasserts the next cycle unless re-triggered.
- Back-to-back frames at full rate (beat_valid every cycle) produce frame_valid every 4th cycle and no errors.
- There is no backpressure. Every beat is consumed in the cycle it is valid.
- Reset mid-frame discards the partial frame. The next frame must start at lane 0.

## Structure
- Shared package lane_pkg:
  - LANES = 4.
  - SEL_W = 2.
  - typedef lane_word_t as logic [LANES-1:0].
  - typedef lane_sel_t as logic [SEL_W-1:0].
- One sub-module, scan_gap_timer. Ports: clk, rst_n, clear, run, expire. It contains the TW-bit counter and the TIMEOUT compare.
- The top level holds exp/in_frame sequencing, shadow, commit and edge logic.

## Test plan
- Reset, then beats (s,y) = (0,1),(1,0),(2,1),(3,1) on consecutive cycles → q=4'b1101, frame_valid and rise=4'b1101 one cycle after the lane-3 beat, no errors.
- The same frame sent twice, then (0,0),(1,0),(2,1),(3,1) → second commit gives frame_valid=1, rise=0. Third commit gives q=4'b1100, rise=0.
- Beats (0,1),(2,1) → sync_err pulse after the s=2 beat, q holds its previous value. A following (0,0),(1,1),(2,0),(3,0) commits q=4'b0010.
- Beats (0,1),(1,1),(0,0),(1,0),(2,0),(3,1) → one sync_err on the second s=0 beat, which restarts the frame. Commit gives q=4'b1000.
- TIMEOUT=16: beat (0,1), then 16 idle cycles → timeout_err pulse, q unchanged. With a beat on the 16th idle cycle instead, there is no timeout_err.
- rst_n pulled low after (0,1),(1,1) → all outputs 0 immediately. After release, (2,1),(3,1) give sync_err, not a commit.

Source files
------------

// File: rtl/lane_pkg.sv
// Shared lane definitions for the scanned 4-lane link.
package lane_pkg;
  localparam int LANES = 4;
  localparam int SEL_W = 2;

  typedef logic [LANES-1:0] lane_word_t;
  typedef logic [SEL_W-1:0] lane_sel_t;
endpackage

// File: rtl/scan_gap_timer.sv
// Counts idle cycles between beats of a frame and flags when the allowed gap is used up.
module scan_gap_timer #(
  parameter int TIMEOUT = 16,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  logic [TW-1:0] timer;

  // Expiry is combinational so the owner can abort the frame on the same edge.
  assign expire = run && (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (clear || expire) begin
      timer <= '0;
    end else if (run) begin
      timer <= timer + TW'(1);
    end
  end

endmodule

// File: rtl/demux4_scan_receiver.sv
// Rebuilds the 4-bit lane word from in-order serial beats and commits it atomically per frame.
module demux4_scan_receiver
  import lane_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       y_in,
  input  lane_sel_t  s_in,
  input  logic       beat_valid,
  output lane_word_t q,
  output logic       frame_valid,
  output lane_word_t rise,
  output logic       sync_err,
  output logic       timeout_err
);

  lane_word_t shadow;
  lane_sel_t  expLane;
  logic       inFrame;
  logic       beatInOrder;
  logic       lastLane;
  lane_word_t newWord;
  logic       gapClear;
  logic       gapRun;
  logic       gapExpire;

  assign beatInOrder = beat_valid && (s_in == expLane);
  assign lastLane    = (expLane == lane_sel_t'(LANES - 1));
  assign newWord     = {y_in, shadow[LANES-2:0]};

  // Any beat restarts the gap count; outside a frame the timer is held at zero.
  assign gapClear = beat_valid || !inFrame;
  assign gapRun   = inFrame && !beat_valid;

  scan_gap_timer #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_gapTimer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (gapClear),
    .run    (gapRun),
    .expire (gapExpire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= '0;
      expLane     <= '0;
      inFrame     <= 1'b0;
      q           <= '0;
      frame_valid <= 1'b0;
      rise        <= '0;
      sync_err    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      rise        <= '0;
      sync_err    <= 1'b0;
      timeout_err <= 1'b0;

      if (beatInOrder) begin
        shadow[expLane] <= y_in;
        expLane         <= expLane + lane_sel_t'(1);
        inFrame         <= !lastLane;
        if (lastLane) begin
          q           <= newWord;
          frame_valid <= 1'b1;
          rise        <= newWord & ~q;
        end
      end else if (beat_valid) begin
        // An out-of-order lane-0 beat is still a valid frame start, so keep it.
        sync_err <= 1'b1;
        if (s_in == '0) begin
          shadow[0] <= y_in;
          expLane   <= lane_sel_t'(1);
          inFrame   <= 1'b1;
        end else begin
          expLane <= '0;
          inFrame <= 1'b0;
        end
      end else if (gapExpire) begin
        timeout_err <= 1'b1;
        expLane     <= '0;
        inFrame     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_demux4_scan_receiver.sv
// Bench for demux4_scan_receiver: directed vector table, corner sequences, random run vs frame model.
module tb_demux4_scan_receiver;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       y_in = 1'b0;
  logic [1:0] s_in = 2'd0;
  logic       beat_valid = 1'b0;
  logic [3:0] q;
  logic       frame_valid;
  logic [3:0] rise;
  logic       sync_err;
  logic       timeout_err;

  int tests = 0;
  int fails = 0;

  demux4_scan_receiver #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .y_in        (y_in),
    .s_in        (s_in),
    .beat_valid  (beat_valid),
    .q           (q),
    .frame_valid (frame_valid),
    .rise        (rise),
    .sync_err    (sync_err),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  wire [10:0] obs = {q, frame_valid, rise, sync_err, timeout_err};

  typedef struct {
    logic       bv;
    logic [1:0] s;
    logic       y;
    logic [3:0] eq;
    logic       efv;
    logic [3:0] er;
    logic       es;
    logic       et;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic bv, input logic [1:0] s, input logic y,
                               input logic [3:0] eq, input logic efv, input logic [3:0] er,
                               input logic es, input logic et);
    vec_t v;
    v.bv = bv; v.s = s; v.y = y; v.eq = eq; v.efv = efv; v.er = er; v.es = es; v.et = et;
    return v;
  endfunction

  function automatic logic [10:0] pack(input logic [3:0] eq, input logic efv, input logic [3:0] er,
                                       input logic es, input logic et);
    return {eq, efv, er, es, et};
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got q/fv/rise/sync/to=%b expected %b", name, act, exp);
    end
  endtask

  // Present one cycle of input, then let the edge happen and settle.
  task automatic step(input logic bv, input logic [1:0] s, input logic y);
    beat_valid = bv;
    s_in       = s;
    y_in       = y;
    @(posedge clk);
    #1;
  endtask

  // Frame-level reference: a list of lane bits captured in order so far.
  bit         part[$];
  int         gap = 0;
  logic [3:0] mq = 4'd0;

  task automatic modelReset();
    part.delete();
    gap = 0;
    mq  = 4'd0;
  endtask

  task automatic modelStep(input logic bv, input logic [1:0] s, input logic y,
                           output logic [10:0] exp);
    logic       efv, es, et;
    logic [3:0] er, nw;
    efv = 1'b0; es = 1'b0; et = 1'b0; er = 4'd0;
    if (bv) begin
      gap = 0;
      if (int'(s) == part.size()) begin
        part.push_back(y);
        if (part.size() == 4) begin
          nw  = {part[3], part[2], part[1], part[0]};
          er  = nw & ~mq;
          mq  = nw;
          efv = 1'b1;
          part.delete();
        end
      end else begin
        es = 1'b1;
        part.delete();
        if (s == 2'd0) part.push_back(y);
      end
    end else if (part.size() > 0) begin
      gap++;
      if (gap == TIMEOUT) begin
        et = 1'b1;
        part.delete();
        gap = 0;
      end
    end
    exp = {mq, efv, er, es, et};
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] exp;
    logic        bv, y;
    logic [1:0]  s;
    int          idleLeft;
    int          r;

    // Directed frames: plain, repeated, sync loss, restart on lane 0.
    vecs.push_back(mkv(1, 0, 1, 4'b0000, 0, 4'b0000, 0, 0));
    vecs.push_back(mkv(1, 1, 0, 4'b0000, 0, 4'b0000, 0, 0));
    vecs.push_back(mkv(1, 2, 1, 4'b0000, 0, 4'b0000, 0, 0));
    vecs.push_back(mkv(1, 3, 1, 4'b1101, 1, 4'b1101, 0, 0));
    vecs.push_back(mkv(1, 0, 1, 4'b1101, 0, 4'b0000, 0, 0));
    vecs.push_back(mkv(1, 1, 0, 4'b1101, 0, 4'b0000, 0, 0));
    vecs.push_back(mkv(1, 2, 1, 4'b1101, 0, 4'b0000, 0, 0));
    vecs.push_back(mkv(1, 3, 1, 4'b1101, 1, 4'b0000, 0, 0));
    vecs.push_back(mkv(1, 0, 0, 4'b1101, 0, 4'b0000, 0, 0));
    vecs.push_back(mkv(1, 1, 0, 4'b1101, 0, 4'b0000, 0, 0));
    vecs.push_back(mkv(1, 2, 1, 4'b1101, 0, 4'b0000, 0, 0));
    vecs.push_back(mkv(1, 3, 1, 4'b1100, 1, 4'b0000, 0, 0));
    vecs.push_back(mkv(1, 0, 1, 4'b1100, 0, 4'b0000, 0, 0));
    vecs.push_back(mkv(1, 2, 1, 4'b1100, 0, 4'b0000, 1, 0));
    vecs.push_back(mkv(1, 0, 0, 4'b1100, 0, 4'b0000, 0, 0));
    vecs.push_back(mkv(1, 1, 1, 4'b1100, 0, 4'b0000, 0, 0));
    vecs.push_back(mkv(1, 2, 0, 4'b1100, 0, 4'b0000, 0, 0));
    vecs.push_back(mkv(1, 3, 0, 4'b0010, 1, 4'b0010, 0, 0));
    vecs.push_back(mkv(1, 0, 1, 4'b0010, 0, 4'b0000, 0, 0));
    vecs.push_back(mkv(1, 1, 1, 4'b0010, 0, 4'b0000, 0, 0));
    vecs.push_back(mkv(1, 0, 0, 4'b0010, 0, 4'b0000, 1, 0));
    vecs.push_back(mkv(1, 1, 0, 4'b0010, 0, 4'b0000, 0, 0));
    vecs.push_back(mkv(1, 2, 0, 4'b0010, 0, 4'b0000, 0, 0));
    vecs.push_back(mkv(1, 3, 1, 4'b1000, 1, 4'b1000, 0, 0));

    rst_n = 1'b0;
    #12;
    check("reset_state", obs, 11'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].bv, vecs[i].s, vecs[i].y);
      check($sformatf("vec%0d", i), obs,
            pack(vecs[i].eq, vecs[i].efv, vecs[i].er, vecs[i].es, vecs[i].et));
    end

    // Timeout: 16 idle cycles after a lane-0 beat abandon the frame.
    step(1, 0, 1);
    for (int i = 1; i <= 15; i++) begin
      step(0, 0, 0);
      check($sformatf("idle%0d_no_timeout", i), obs, pack(4'b1000, 0, 4'b0000, 0, 0));
    end
    step(0, 0, 0);
    check("timeout_fires", obs, pack(4'b1000, 0, 4'b0000, 0, 1));
    step(0, 0, 0);
    check("timeout_one_cycle", obs, pack(4'b1000, 0, 4'b0000, 0, 0));

    // A beat on the 16th idle cycle wins over the expiring timer.
    step(1, 0, 1);
    for (int i = 1; i <= 15; i++) step(0, 0, 0);
    step(1, 1, 0);
    check("beat_beats_timeout", obs, pack(4'b1000, 0, 4'b0000, 0, 0));
    step(1, 2, 1);
    step(1, 3, 0);
    check("late_frame_commit", obs, pack(4'b0101, 1, 4'b0101, 0, 0));

    // Asynchronous reset mid-frame.
    step(1, 0, 1);
    step(1, 1, 1);
    beat_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", obs, 11'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 2, 1);
    check("post_reset_lane2_sync", obs, pack(4'b0000, 0, 4'b0000, 1, 0));
    step(1, 3, 1);
    check("post_reset_lane3_sync", obs, pack(4'b0000, 0, 4'b0000, 1, 0));
    step(0, 0, 0);
    check("post_reset_idle", obs, pack(4'b0000, 0, 4'b0000, 0, 0));

    // Random traffic against the frame model.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    modelReset();
    idleLeft = 0;
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      y = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      if (idleLeft > 0) begin
        bv = 1'b0;
        idleLeft--;
      end else if (r < 4) begin
        bv = 1'b0;
        idleLeft = $urandom_range(12, 18);
      end else if (r < 14) begin
        bv = 1'b0;
      end else begin
        bv = 1'b1;
        if (r >= 22) s = 2'(part.size());
      end
      modelStep(bv, s, y, exp);
      step(bv, s, y);
      check($sformatf("rand%0d", c), obs, exp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
